// File: rtl/slow_ddr3_user_model.sv
// slow_ddr3_user_model: responder stand-in for the slowDDR3 sysIO user port.
// Backed by a 2^MEM_AW word RAM. It models the power-up init delay, fixed
// write/read latencies and periodic refresh stalls.
// Ports: clk, reset (async, active-high); sysIO_address, sysIO_dataWr_valid,
// sysIO_dataWr_payload, sysIO_dataRd_ready in; sysIO_dataWr_ready,
// sysIO_dataRd_valid, sysIO_dataRd_payload, sysIO_initFin out (registered).
module slow_ddr3_user_model #(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_AW         = 16,
  parameter int INIT_CYCLES    = 64,
  parameter int WR_LATENCY     = 4,
  parameter int RD_LATENCY     = 8,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] sysIO_address,
  input  logic                  sysIO_dataWr_valid,
  input  logic [DATA_WIDTH-1:0] sysIO_dataWr_payload,
  output logic                  sysIO_dataWr_ready,
  input  logic                  sysIO_dataRd_ready,
  output logic                  sysIO_dataRd_valid,
  output logic [DATA_WIDTH-1:0] sysIO_dataRd_payload,
  output logic                  sysIO_initFin
);

  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
  localparam logic [31:0] WR_LAST   = 32'(WR_LATENCY);
  localparam logic [31:0] RD_LAST   = 32'(RD_LATENCY);
  localparam logic [31:0] REF_LAST  = 32'(REFRESH_PERIOD - 1);
  localparam logic [31:0] RC_LAST   = 32'(REFRESH_CYCLES);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_REFRESH
  } state_t;

  state_t                state;
  logic [31:0]           cnt;
  logic [31:0]           ref_cnt;
  logic                  ref_pend;
  logic [MEM_AW-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_commit;

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

  // Upper address bits alias away on purpose.
  logic unused_addr_hi;
  assign unused_addr_hi = ^sysIO_address[ADDR_WIDTH-1:MEM_AW];

  assign wr_commit = (state == S_WRITE) && (cnt == WR_LAST);

  // RAM has no reset so contents survive a reset; a reset drops state
  // out of S_WRITE immediately, cancelling an in-flight commit.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_INIT;
      cnt                  <= '0;
      ref_cnt              <= '0;
      ref_pend             <= 1'b0;
      addr_q               <= '0;
      wdata_q              <= '0;
      sysIO_dataWr_ready   <= 1'b0;
      sysIO_dataRd_valid   <= 1'b0;
      sysIO_dataRd_payload <= '0;
      sysIO_initFin        <= 1'b0;
    end else begin
      sysIO_dataWr_ready <= 1'b0;
      sysIO_dataRd_valid <= 1'b0;

      // Refresh timer free-runs once init is done, independent of FSM.
      if (sysIO_initFin) begin
        if (ref_cnt == REF_LAST) begin
          ref_cnt  <= '0;
          ref_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 32'd1;
        end
      end

      unique case (state)
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt           <= '0;
            sysIO_initFin <= 1'b1;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_IDLE: begin
          // Busy states count from 1 so they finish after exactly N edges.
          cnt <= 32'd1;
          if (ref_pend) begin
            ref_pend <= 1'b0;
            state    <= S_REFRESH;
          end else if (sysIO_dataWr_valid) begin
            addr_q  <= sysIO_address[MEM_AW-1:0];
            wdata_q <= sysIO_dataWr_payload;
            state   <= S_WRITE;
          end else if (sysIO_dataRd_ready) begin
            addr_q <= sysIO_address[MEM_AW-1:0];
            state  <= S_READ;
          end
        end
        S_WRITE: begin
          if (cnt == WR_LAST) begin
            sysIO_dataWr_ready <= 1'b1;
            state              <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_READ: begin
          if (cnt == RD_LAST) begin
            sysIO_dataRd_payload <= mem[addr_q];
            sysIO_dataRd_valid   <= 1'b1;
            state                <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_REFRESH: begin
          if (cnt == RC_LAST) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_ddr3_user_model.sv
// tb_slow_ddr3_user_model: directed + randomized bench for slow_ddr3_user_model.
// Timing expectations come from an edge-level schedule model of accepts and refreshes.
module tb_slow_ddr3_user_model;

  localparam int WL = 4;
  localparam int RL = 8;
  localparam int RC = 26;
  localparam int RP = 780;
  localparam int IC = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [26:0] addr = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_rdy;
  logic        rd_req = 1'b0;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        init_fin;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int free_e = 0;
  int next_due = 0;
  int fin_e = 0;

  logic [15:0] mdl [int];

  slow_ddr3_user_model dut (
    .clk                  (clk),
    .reset                (reset),
    .sysIO_address        (addr),
    .sysIO_dataWr_valid   (wr_valid),
    .sysIO_dataWr_payload (wr_data),
    .sysIO_dataWr_ready   (wr_rdy),
    .sysIO_dataRd_ready   (rd_req),
    .sysIO_dataRd_valid   (rd_vld),
    .sysIO_dataRd_payload (rd_data),
    .sysIO_initFin        (init_fin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Request driven at negedge c: find the accept edge, servicing any
  // refresh that became pending (at edge next_due) before that edge.
  task automatic plan(input int c, input int lat, output int a);
    int st;
    a = imax(c + 1, free_e);
    while (next_due < a) begin
      st       = imax(next_due + 1, free_e);
      free_e   = st + RC + 1;
      next_due = next_due + RP;
      a        = imax(c + 1, free_e);
    end
    free_e = a + lat + 1;
  endtask

  task automatic wait_pulse(input bit wr, input int exp_e, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr ? wr_rdy : rd_vld) && n < 200);
    chk(tag, cyc, exp_e);
  endtask

  task automatic do_reset(input int hold);
    int r;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_initfin", init_fin, 0);
    chk("rst_wr_ready", wr_rdy, 0);
    chk("rst_rd_valid", rd_vld, 0);
    chk("rst_rd_payload", rd_data, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("rst_hold_wr_ready", wr_rdy, 0);
    end
    reset = 1'b0;
    r = cyc;
    while (cyc < r + IC) begin
      @(negedge clk);
      if (cyc < r + IC)
        chk("init_quiet", {init_fin, wr_rdy, rd_vld}, 0);
    end
    chk("init_rise", init_fin, 1);
    fin_e    = cyc;
    free_e   = fin_e + 1;
    next_due = fin_e + RP;
  endtask

  initial begin
    int a;
    int lo;

    // Requests held high through reset/init; write must win over read.
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    addr     = 27'h10005;
    wr_data  = 16'hBEEF;
    do_reset(3);
    plan(cyc, WL, a);
    wait_pulse(1'b1, a + WL, "prio_wr_pulse");
    wr_valid = 1'b0;
    plan(cyc, RL, a);
    wait_pulse(1'b0, a + RL, "prio_rd_pulse");
    chk("alias_rd_hi", rd_data, 16'hBEEF);
    addr = 27'h00005;
    plan(cyc, RL, a);
    wait_pulse(1'b0, a + RL, "alias_rd_pulse");
    chk("alias_rd_lo", rd_data, 16'hBEEF);
    rd_req = 1'b0;
    mdl[5] = 16'hBEEF;

    // Random traffic with aliased upper address bits.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      lo   = 16 + int'($urandom_range(0, 63));
      addr = 27'(($urandom & 32'h07FF_0000) | lo);
      if ($urandom_range(0, 1) == 0 || !mdl.exists(lo)) begin
        wr_data  = 16'($urandom);
        wr_valid = 1'b1;
        plan(cyc, WL, a);
        wait_pulse(1'b1, a + WL, "rnd_wr_pulse");
        wr_valid = 1'b0;
        mdl[lo]  = wr_data;
      end else begin
        rd_req = 1'b1;
        plan(cyc, RL, a);
        wait_pulse(1'b0, a + RL, "rnd_rd_pulse");
        rd_req = 1'b0;
        chk("rnd_rd_data", rd_data, mdl[lo]);
      end
    end

    // Idle past the first refresh, then read: accept waits for REFRESH.
    do_reset(2);
    while (cyc < fin_e + 799) @(negedge clk);
    addr   = 27'h10005;
    rd_req = 1'b1;
    plan(cyc, RL, a);
    wait_pulse(1'b0, a + RL, "refresh_rd_pulse");
    rd_req = 1'b0;
    chk("ram_kept_rd", rd_data, 16'hBEEF);

    // Reset two cycles after a write accept must cancel the write.
    addr     = 27'd7;
    wr_data  = 16'h1234;
    wr_valid = 1'b1;
    plan(cyc, WL, a);
    while (cyc < a + 1) @(negedge clk);
    wr_valid = 1'b0;
    do_reset(2);
    rd_req = 1'b1;
    plan(cyc, RL, a);
    wait_pulse(1'b0, a + RL, "midrst_rd_pulse");
    rd_req = 1'b0;
    chk("midrst_no_write", {31'b0, rd_data === 16'h1234}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
